// File: rtl/sia_work_dispatch.sv
// ---------------------------------------------------------------------------
// sia_work_dispatch
//
// Multi-core front end for Sia mining. A single 640-bit work header and a
// 64-bit target are accepted from the host. The 32-bit nonce space is split
// evenly across NCORES siacore instances by giving each core its own starting
// nonce. Found/busy status is gathered from every core. Simultaneous hits are
// reported one per cycle, lowest core index first. A pulse is raised when
// every core has run out of nonces without a hit.
//
// Optional feature: define SIA_DISPATCH_WDT_EN to build a watchdog that aborts
// the cores once a job has spent WDT_CYCLES cycles in RUN/REPORT. When it is
// not defined, no counter is built and wdt_expired is tied low.
//
// Parameters:
//   NCORES      number of siacore instances (power of two, 1..16)
//   STOP_FIRST  1: abort all cores after the first hit batch, 0: keep mining
//   WDT_CYCLES  watchdog limit in clk cycles (watchdog build only)
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     one-cycle pulse: new work on in_work/in_target
//   in_work      640-bit header; nonce field [287:256] is byte-reversed
//   in_target    64-bit difficulty target
//   core_valid   per-core one-cycle load pulse
//   core_work    per-core header with that core's start nonce substituted
//   core_target  registered copy of in_target
//   core_abort   one-cycle pulse: all cores drop their current work
//   core_busy    per-core busy
//   core_found   per-core hit pulse
//   core_nonce   per-core nonce (natural byte order), valid with core_found
//   found        one-cycle hit report
//   nonce        reported nonce, valid with found
//   found_id     index of the reporting core
//   busy         high from accepted work until the return to IDLE
//   exhausted    one-cycle pulse: every core finished without a hit
//   wdt_expired  watchdog pulse (0 without the watchdog build)
// ---------------------------------------------------------------------------
module sia_work_dispatch #(
    parameter int NCORES     = 4,
    parameter int STOP_FIRST = 1,
    parameter int WDT_CYCLES = 3000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [639:0]           in_work,
    input  logic [63:0]            in_target,
    output logic [NCORES-1:0]      core_valid,
    output logic [NCORES*640-1:0]  core_work,
    output logic [63:0]            core_target,
    output logic                   core_abort,
    input  logic [NCORES-1:0]      core_busy,
    input  logic [NCORES-1:0]      core_found,
    input  logic [NCORES*32-1:0]   core_nonce,
    output logic                   found,
    output logic [31:0]            nonce,
    output logic [3:0]             found_id,
    output logic                   busy,
    output logic                   exhausted,
    output logic                   wdt_expired
);

    // Each core's slice of the nonce space starts this many bits up.
    localparam int SHIFT = 32 - $clog2(NCORES);

    // Reject configurations the stride arithmetic cannot cover.
    if (NCORES < 1 || NCORES > 16 || (NCORES & (NCORES - 1)) != 0 || WDT_CYCLES < 1) begin : g_param_check
        $error("sia_work_dispatch: unsupported NCORES or WDT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} state_t;

    state_t             state;
    logic [NCORES-1:0]  pend;
    logic [NCORES-1:0]  started;
    logic [NCORES-1:0]  done;
    logic [31:0]        nonce_lat [NCORES];

    logic [NCORES*640-1:0] work_split;
    logic [NCORES-1:0]     pend_set;
    logic [NCORES-1:0]     pend_all;
    logic [NCORES-1:0]     sel_mask;
    logic [NCORES-1:0]     started_nx;
    logic [NCORES-1:0]     done_nx;
    logic [31:0]           sel_nonce;
    logic [3:0]            sel_id;
    logic                  wdt_hit;

    function automatic logic [31:0] byteswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // The header carries the nonce byte-reversed, so arithmetic on the start
    // value happens in natural order and is swapped back on the way out.
    always_comb begin
        work_split = '0;
        for (int i = 0; i < NCORES; i++) begin
            work_split[i*640 +: 640]     = in_work;
            work_split[i*640 + 256 +: 32] =
                byteswap(byteswap(in_work[287:256]) + (32'(i) << SHIFT));
        end
    end

    // Hits that arrive this cycle are merged with those already pending so a
    // hit is reported in the very next cycle. The downward scan leaves the
    // lowest pending index selected, with a fresh nonce taking precedence
    // over a stale latched one.
    always_comb begin
        pend_set   = (state == RUN || state == REPORT) ? core_found : '0;
        pend_all   = pend | pend_set;
        started_nx = started | core_busy;
        done_nx    = done | (started & ~core_busy);
        sel_mask   = '0;
        sel_id     = '0;
        sel_nonce  = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (pend_all[i]) begin
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
                sel_id      = 4'(i);
                sel_nonce   = pend_set[i] ? core_nonce[i*32 +: 32] : nonce_lat[i];
            end
        end
    end

`ifdef SIA_DISPATCH_WDT_EN
    logic [31:0] wdt_cnt;

    // Fires on the cycle whose increment brings the count to the limit.
    assign wdt_hit = (wdt_cnt + 32'd1) >= 32'(WDT_CYCLES);
`else
    assign wdt_hit     = 1'b0;
    assign wdt_expired = 1'b0;
`endif

    // Dispatcher FSM. Priority in RUN/REPORT: new work preempts everything,
    // then pending hits, then the watchdog, then the STOP_FIRST abort, then
    // exhaustion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= '0;
            started     <= '0;
            done        <= '0;
            for (int i = 0; i < NCORES; i++) nonce_lat[i] <= '0;
            core_valid  <= '0;
            core_work   <= '0;
            core_target <= '0;
            core_abort  <= 1'b0;
            found       <= 1'b0;
            nonce       <= '0;
            found_id    <= '0;
            busy        <= 1'b0;
            exhausted   <= 1'b0;
`ifdef SIA_DISPATCH_WDT_EN
            wdt_cnt     <= '0;
            wdt_expired <= 1'b0;
`endif
        end else begin
            core_valid <= '0;
            core_abort <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
`ifdef SIA_DISPATCH_WDT_EN
            wdt_expired <= 1'b0;
`endif
            for (int i = 0; i < NCORES; i++) begin
                if (pend_set[i]) nonce_lat[i] <= core_nonce[i*32 +: 32];
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        core_work   <= work_split;
                        core_target <= in_target;
                        core_valid  <= '1;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end

                LOAD: begin
                    started <= '0;
                    done    <= '0;
                    pend    <= '0;
`ifdef SIA_DISPATCH_WDT_EN
                    wdt_cnt <= '0;
`endif
                    state   <= RUN;
                end

                RUN, REPORT: begin
                    started <= started_nx;
                    done    <= done_nx;
`ifdef SIA_DISPATCH_WDT_EN
                    wdt_cnt <= wdt_cnt + 32'd1;
`endif
                    if (in_valid) begin
                        core_abort  <= 1'b1;
                        pend        <= '0;
                        core_work   <= work_split;
                        core_target <= in_target;
                        core_valid  <= '1;
                        state       <= LOAD;
                    end else if (|pend_all) begin
                        found    <= 1'b1;
                        nonce    <= sel_nonce;
                        found_id <= sel_id;
                        pend     <= pend_all & ~sel_mask;
                        state    <= REPORT;
                    end else if (wdt_hit) begin
`ifdef SIA_DISPATCH_WDT_EN
                        wdt_expired <= 1'b1;
`endif
                        core_abort <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (state == REPORT && STOP_FIRST != 0) begin
                        core_abort <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (&done_nx) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sia_work_dispatch.sv
// ---------------------------------------------------------------------------
// tb_sia_work_dispatch
//
// Directed bench for sia_work_dispatch with NCORES=4 and STOP_FIRST=1. Inputs
// change 1 ns after a rising edge and outputs are sampled at the same point,
// so each applyStimulus call shows the DUT state for the following cycle.
// ---------------------------------------------------------------------------
module tb_sia_work_dispatch;

    localparam int NC = 4;
`ifdef SIA_DISPATCH_WDT_EN
    localparam int WDT = 20;
`else
    localparam int WDT = 3000;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [639:0]       in_work;
    logic [63:0]        in_target;
    logic [NC-1:0]      core_valid;
    logic [NC*640-1:0]  core_work;
    logic [63:0]        core_target;
    logic               core_abort;
    logic [NC-1:0]      core_busy;
    logic [NC-1:0]      core_found;
    logic [NC*32-1:0]   core_nonce;
    logic               found;
    logic [31:0]        nonce;
    logic [3:0]         found_id;
    logic               busy;
    logic               exhausted;
    logic               wdt_expired;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sia_work_dispatch #(
        .NCORES     (NC),
        .STOP_FIRST (1),
        .WDT_CYCLES (WDT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_work     (in_work),
        .in_target   (in_target),
        .core_valid  (core_valid),
        .core_work   (core_work),
        .core_target (core_target),
        .core_abort  (core_abort),
        .core_busy   (core_busy),
        .core_found  (core_found),
        .core_nonce  (core_nonce),
        .found       (found),
        .nonce       (nonce),
        .found_id    (found_id),
        .busy        (busy),
        .exhausted   (exhausted),
        .wdt_expired (wdt_expired)
    );

    task automatic checkOutput(input string tag, input logic [639:0] act, input logic [639:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [639:0] w, input logic [3:0] b,
                                 input logic [3:0] f, input logic [127:0] n);
        in_valid   = iv;
        in_work    = w;
        core_busy  = b;
        core_found = f;
        core_nonce = n;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [639:0] mkWork(input logic [31:0] field, input logic [31:0] fill);
        logic [639:0] w;
        w = {20{fill}};
        w[287:256] = field;
        return w;
    endfunction

    // fields packed {core3, core2, core1, core0}, each already byte-reversed
    task automatic checkSlices(input string tag, input logic [127:0] fields, input logic [31:0] fill);
        for (int i = 0; i < NC; i++) begin
            checkOutput($sformatf("%s_work%0d", tag, i), core_work[i*640 +: 640],
                        mkWork(fields[i*32 +: 32], fill));
        end
    endtask

    logic [639:0] w1, w3, w5;

    initial begin
        w1 = mkWork(32'h78563412, 32'hA5C30F1E);
        w3 = mkWork(32'h00000000, 32'h5A5A5A5A);
        w5 = mkWork(32'hF0FFFFFF, 32'h13579BDF);

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_work    = '0;
        in_target  = '0;
        core_busy  = '0;
        core_found = '0;
        core_nonce = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_core_valid", core_valid, 0);
        checkOutput("rst_core_work0", core_work[639:0], 0);
        checkOutput("rst_core_work3", core_work[2559:1920], 0);
        checkOutput("rst_core_target", core_target, 0);
        checkOutput("rst_abort", core_abort, 0);
        checkOutput("rst_found", found, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_exhausted", exhausted, 0);
        checkOutput("rst_wdt", wdt_expired, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Work acceptance and start nonces 0x12345678 + i*0x40000000
        in_target = 64'h0000_0000_FFFF_0000;
        applyStimulus(1, w1, 0, 0, 0);
        checkOutput("load_core_valid", core_valid, 4'hF);
        checkOutput("load_busy", busy, 1);
        checkOutput("load_target", core_target, 64'h0000_0000_FFFF_0000);
        checkSlices("t1", {32'hD2345678 == 0 ? 32'h0 : 32'h785634D2, 32'h78563492, 32'h78563452, 32'h78563412},
                    32'hA5C30F1E);
        // in_valid during LOAD must not replace the work
        applyStimulus(1, mkWork(32'h01020304, 32'h0), 0, 0, 0);
        checkOutput("run_core_valid", core_valid, 0);
        checkOutput("load_ignore_field", core_work[287:256], 32'h78563412);
        checkOutput("load_ignore_abort", core_abort, 0);

        // Single hit from core 2, then abort and return to idle
        applyStimulus(0, w1, 4'hF, 0, 0);
        checkOutput("t2_no_found", found, 0);
        applyStimulus(0, w1, 4'hF, 4'b0100, {32'h0, 32'h9234567A, 64'h0});
        checkOutput("t2_found", found, 1);
        checkOutput("t2_nonce", nonce, 32'h9234567A);
        checkOutput("t2_id", found_id, 2);
        checkOutput("t2_abort_early", core_abort, 0);
        checkOutput("t2_busy_report", busy, 1);
        applyStimulus(0, w1, 4'hF, 0, 0);
        checkOutput("t2_abort", core_abort, 1);
        checkOutput("t2_found_clear", found, 0);
        checkOutput("t2_busy_idle", busy, 0);
        applyStimulus(0, w1, 0, 0, 0);
        checkOutput("t2_abort_clear", core_abort, 0);
        checkOutput("t2_busy_after", busy, 0);

        // Simultaneous hits from cores 1 and 3; base 0 -> starts 0,4,8,C << 28
        applyStimulus(1, w3, 0, 0, 0);
        checkSlices("t3", {32'h000000C0, 32'h00000080, 32'h00000040, 32'h00000000}, 32'h5A5A5A5A);
        applyStimulus(0, w3, 0, 0, 0);
        applyStimulus(0, w3, 0, 4'b1010, {32'h33333333, 32'h0, 32'h11111111, 32'h0});
        checkOutput("t3_found_a", found, 1);
        checkOutput("t3_id_a", found_id, 1);
        checkOutput("t3_nonce_a", nonce, 32'h11111111);
        applyStimulus(0, w3, 0, 0, 0);
        checkOutput("t3_found_b", found, 1);
        checkOutput("t3_id_b", found_id, 3);
        checkOutput("t3_nonce_b", nonce, 32'h33333333);
        checkOutput("t3_abort_early", core_abort, 0);
        applyStimulus(0, w3, 0, 0, 0);
        checkOutput("t3_found_end", found, 0);
        checkOutput("t3_abort", core_abort, 1);

        // Exhaustion without any hit
        applyStimulus(1, w1, 0, 0, 0);
        applyStimulus(0, w1, 0, 0, 0);
        applyStimulus(0, w1, 4'hF, 0, 0);
        checkOutput("t4_exh_early", exhausted, 0);
        applyStimulus(0, w1, 4'b1000, 0, 0);
        checkOutput("t4_exh_partial", exhausted, 0);
        checkOutput("t4_busy_partial", busy, 1);
        applyStimulus(0, w1, 0, 0, 0);
        checkOutput("t4_exhausted", exhausted, 1);
        checkOutput("t4_found", found, 0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_abort", core_abort, 0);
        applyStimulus(0, w1, 0, 0, 0);
        checkOutput("t4_exh_clear", exhausted, 0);

        // Preemption in RUN with a same-cycle hit that must be discarded;
        // base 0xFFFFFFF0 wraps for cores 1..3
        applyStimulus(1, w1, 0, 0, 0);
        applyStimulus(0, w1, 0, 0, 0);
        in_target = 64'h1122_3344_5566_7788;
        applyStimulus(1, w5, 0, 4'b0010, {64'h0, 32'hDEADBEEF, 32'h0});
        checkOutput("t5_abort", core_abort, 1);
        checkOutput("t5_core_valid", core_valid, 4'hF);
        checkOutput("t5_found", found, 0);
        checkOutput("t5_busy", busy, 1);
        checkOutput("t5_target", core_target, 64'h1122_3344_5566_7788);
        checkSlices("t5", {32'hF0FFFFBF, 32'hF0FFFF7F, 32'hF0FFFF3F, 32'hF0FFFFFF}, 32'h13579BDF);
        applyStimulus(0, w5, 0, 0, 0);
        checkOutput("t5_found_run", found, 0);
        checkOutput("t5_abort_clear", core_abort, 0);
        applyStimulus(0, w5, 0, 0, 0);
        checkOutput("t5_found_late", found, 0);

        // Cores held busy after a fresh LOAD: with the watchdog (limit 20) the
        // pulse lands on the 21st sampled cycle after LOAD, otherwise never.
        applyStimulus(1, w3, 4'hF, 0, 0);
        checkOutput("t6_load", core_valid, 4'hF);
        for (int k = 1; k <= 21; k++) begin
            applyStimulus(0, w3, 4'hF, 0, 0);
`ifdef SIA_DISPATCH_WDT_EN
            checkOutput($sformatf("t6_wdt_%0d", k), wdt_expired, (k == 21));
            checkOutput($sformatf("t6_abort_%0d", k), core_abort, (k == 21));
`else
            checkOutput($sformatf("t6_wdt_%0d", k), wdt_expired, 0);
            checkOutput($sformatf("t6_abort_%0d", k), core_abort, 0);
`endif
        end

        // Asynchronous reset mid-operation clears busy without an edge
        applyStimulus(1, w1, 0, 0, 0);
        applyStimulus(0, w1, 4'hF, 0, 0);
        checkOutput("t7_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("t7_busy_rst", busy, 0);
        checkOutput("t7_abort_rst", core_abort, 0);
        checkOutput("t7_work_rst", core_work[639:0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
